// File: rtl/link_flit_tx_pkg.sv
// Shared constants, FSM state type and flit formatting helper for the
// link flit transmitter.
package link_pkg;

    localparam int FLIT_W    = 11;
    localparam int PAYLOAD_W = 10;
    localparam int TAIL_BIT  = 10;
    localparam int MAX_FLITS = 4;
    localparam int DATA_W    = PAYLOAD_W * MAX_FLITS;

    localparam logic [FLIT_W-1:0] LINK_RESET_WORD = 11'h7FF;
    localparam logic [FLIT_W-1:0] LINK_IDLE_WORD  = 11'h000;

    typedef enum logic [1:0] {
        RST_ONES,
        RST_ZEROS,
        IDLE,
        SEND
    } link_state_t;

    // Build flit idx of a buffered packet: payload chunk idx, tail set on the last one.
    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [DATA_W-1:0] data,
        input logic [1:0]        idx,
        input logic [1:0]        last
    );
        logic [FLIT_W-1:0] f;
        int unsigned       base;
        base                 = PAYLOAD_W * int'(idx);
        f                    = '0;
        f[PAYLOAD_W-1:0]     = data[base +: PAYLOAD_W];
        f[TAIL_BIT]          = (idx == last);
        return f;
    endfunction

endpackage

// File: rtl/link_flit_tx_reset_seq.sv
// Link-reset preamble timer: RESET_CYCLES cycles of the "ones" phase followed
// by IDLE_CYCLES cycles of the "zeros" phase. Runs out of reset, and again on
// every start pulse. ones_last / done flag the final cycle of each phase.
module link_reset_seq
    import link_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 60,
    parameter int unsigned IDLE_CYCLES  = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic ones,
    output logic ones_last,
    output logic done
);

    localparam int unsigned MAX_CYCLES = (RESET_CYCLES > IDLE_CYCLES) ? RESET_CYCLES : IDLE_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ONES_END  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZEROS_END = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             ones_phase;
    logic             running;

    // Phase counter: restart on reset/start, count through ones then zeros, then stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            ones_phase <= 1'b1;
            running    <= 1'b1;
        end else if (start) begin
            cnt        <= '0;
            ones_phase <= 1'b1;
            running    <= 1'b1;
        end else if (running) begin
            if (ones_phase) begin
                if (cnt == ONES_END) begin
                    cnt        <= '0;
                    ones_phase <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (cnt == ZEROS_END) begin
                    cnt     <= '0;
                    running <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Phase and end-of-phase flags for the transmitter FSM.
    always_comb begin
        ones      = running && ones_phase;
        ones_last = running && ones_phase && (cnt == ONES_END);
        done      = running && !ones_phase && (cnt == ZEROS_END);
    end

endmodule

// File: rtl/link_flit_tx.sv
// Link flit transmitter: drives a link-reset preamble (ones then zeros),
// then accepts packets of 1..4 ten-bit chunks and serialises them as 11-bit
// flits (bit 10 = tail) under a valid/ready handshake.
// Optional feature macro LINK_TX_STATS_EN adds a 16-bit wrapping flit_count.
module link_flit_tx
    import link_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 60,
    parameter int unsigned IDLE_CYCLES  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] in_data,
    input  logic [1:0]  in_nflits,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        link_reset_req,
    output logic [10:0] link_out,
    output logic        link_valid_out,
    input  logic        link_ready_in
`ifdef LINK_TX_STATS_EN
    ,
    output logic [15:0] flit_count
`endif
);

    link_state_t       state;
    link_state_t       state_next;

    logic [DATA_W-1:0] buf_data;
    logic [1:0]        buf_last;
    logic [1:0]        flit_idx;
    logic              rst_pending;

    logic              accept;
    logic              flit_hs;
    logic              tail_hs;
    logic              seq_start;
    logic              seq_ones;
    logic              seq_ones_last;
    logic              seq_done;

    link_reset_seq #(
        .RESET_CYCLES (RESET_CYCLES),
        .IDLE_CYCLES  (IDLE_CYCLES)
    ) u_reset_seq (
        .clk       (clk),
        .reset     (reset),
        .start     (seq_start),
        .ones      (seq_ones),
        .ones_last (seq_ones_last),
        .done      (seq_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_ONES;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake decodes and link outputs.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        flit_hs        = 1'b0;
        tail_hs        = 1'b0;
        seq_start      = 1'b0;
        in_ready       = 1'b0;
        link_valid_out = 1'b0;
        link_out       = LINK_IDLE_WORD;
        case (state)
            RST_ONES: begin
                link_out = seq_ones ? LINK_RESET_WORD : LINK_IDLE_WORD;
                if (seq_ones_last) begin
                    state_next = RST_ZEROS;
                end
            end
            RST_ZEROS: begin
                link_out = seq_ones ? LINK_RESET_WORD : LINK_IDLE_WORD;
                if (seq_done) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                in_ready = !link_reset_req;
                // A reset request outranks a packet offered in the same cycle.
                if (link_reset_req) begin
                    state_next = RST_ONES;
                    seq_start  = 1'b1;
                end else if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                link_valid_out = 1'b1;
                link_out       = make_flit(buf_data, flit_idx, buf_last);
                if (link_ready_in) begin
                    flit_hs = 1'b1;
                    if (flit_idx == buf_last) begin
                        tail_hs = 1'b1;
                        if (rst_pending || link_reset_req) begin
                            state_next = RST_ONES;
                            seq_start  = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = RST_ONES;
            end
        endcase
    end

    // Packet buffer, flit index and deferred reset request seen mid-packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data    <= '0;
            buf_last    <= '0;
            flit_idx    <= '0;
            rst_pending <= 1'b0;
        end else if (accept) begin
            buf_data    <= in_data;
            buf_last    <= in_nflits;
            flit_idx    <= '0;
            rst_pending <= 1'b0;
        end else if (state == SEND) begin
            if (flit_hs) begin
                flit_idx <= flit_idx + 2'd1;
            end
            if (tail_hs) begin
                rst_pending <= 1'b0;
            end else if (link_reset_req) begin
                rst_pending <= 1'b1;
            end
        end
    end

`ifdef LINK_TX_STATS_EN
    // Count every flit handshake; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_count <= '0;
        end else if (flit_hs) begin
            flit_count <= flit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_link_flit_tx.sv
// Self-checking bench for link_flit_tx: a queue/countdown model of the link
// is compared every cycle, plus directed literal expectations.
module tb_link_flit_tx;

    localparam int RC = 60;
    localparam int IC = 30;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic [39:0] in_data        = '0;
    logic [1:0]  in_nflits      = '0;
    logic        in_valid       = 1'b0;
    logic        in_ready;
    logic        link_reset_req = 1'b0;
    logic [10:0] link_out;
    logic        link_valid_out;
    logic        link_ready_in  = 1'b1;
`ifdef LINK_TX_STATS_EN
    logic [15:0] flit_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: remaining preamble cycles, queue of flits still to leave the link.
    int          m_ones;
    int          m_zeros;
    logic [10:0] m_q[$];
    bit          m_pend;
    int unsigned m_fc;
    bit          primed = 1'b0;

    logic [10:0] seen[$];
    logic [39:0] pkt;

    link_flit_tx #(
        .RESET_CYCLES (RC),
        .IDLE_CYCLES  (IC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_nflits      (in_nflits),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .link_reset_req (link_reset_req),
        .link_out       (link_out),
        .link_valid_out (link_valid_out),
        .link_ready_in  (link_ready_in)
`ifdef LINK_TX_STATS_EN
        ,
        .flit_count     (flit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step at each rising edge using the inputs as they stood before it.
    always @(posedge clk or posedge reset) begin : model_step
        logic [39:0] sh;
        if (reset) begin
            m_ones  = RC;
            m_zeros = IC;
            m_q.delete();
            m_pend  = 1'b0;
            m_fc    = 0;
            primed  = 1'b1;
        end else if (m_ones > 0) begin
            m_ones--;
        end else if (m_zeros > 0) begin
            m_zeros--;
        end else if (m_q.size() > 0) begin
            if (link_reset_req) m_pend = 1'b1;
            if (link_ready_in) begin
                void'(m_q.pop_front());
                m_fc = (m_fc + 1) % 65536;
                if (m_q.size() == 0 && m_pend) begin
                    m_ones  = RC;
                    m_zeros = IC;
                    m_pend  = 1'b0;
                end
            end
        end else if (link_reset_req) begin
            m_ones  = RC;
            m_zeros = IC;
        end else if (in_valid) begin
            for (int k = 0; k <= int'(in_nflits); k++) begin
                sh = in_data >> (10 * k);
                m_q.push_back({(k == int'(in_nflits)), sh[9:0]});
            end
            m_pend = 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin : compare
        bit          e_valid;
        bit          e_ready;
        logic [10:0] e_out;
        if (primed && !reset) begin
            e_valid = (m_ones == 0) && (m_zeros == 0) && (m_q.size() > 0);
            e_ready = (m_ones == 0) && (m_zeros == 0) && (m_q.size() == 0) && !link_reset_req;
            e_out   = (m_ones > 0) ? 11'h7FF : (e_valid ? m_q[0] : 11'h000);
            chk("model_valid", link_valid_out, e_valid);
            chk("model_out", link_out, e_out);
            chk("model_ready", in_ready, e_ready);
`ifdef LINK_TX_STATS_EN
            chk("model_flit_count", flit_count, m_fc);
`endif
            if (link_valid_out && link_ready_in) seen.push_back(link_out);
        end
    end

    // Offer a packet until accepted (bounded); returns one cycle after acceptance.
    task automatic offer(input logic [39:0] d, input logic [1:0] n);
        bit got;
        got       = 1'b0;
        in_data   = d;
        in_nflits = n;
        in_valid  = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("offer_accept", got, 1);
    endtask

    // Wait (bounded) until the transmitter is back in its idle, ready state.
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("wait_idle", ok, 1);
    endtask

    // Skip flits still in flight, then count preamble ones/zeros cycles.
    task automatic measure(output int ones, output int zeros);
        ones  = 0;
        zeros = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (link_valid_out && ones == 0 && zeros == 0) continue;
            if (zeros == 0 && link_out == 11'h7FF && !link_valid_out && !in_ready) ones++;
            else if (link_out == 11'h000 && !link_valid_out && !in_ready) zeros++;
            else break;
        end
    endtask

    initial begin : stimulus
        int o;
        int z;
`ifdef LINK_TX_STATS_EN
        int unsigned need;
`endif
        pkt = {10'h007, 10'h003, 10'h001, 10'h00F};

        // Held in reset: reset word, nothing valid, not ready.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", link_out, 11'h7FF);
        chk("rst_valid", link_valid_out, 0);
        chk("rst_ready", in_ready, 0);
        reset = 1'b0;

        measure(o, z);
        chk("pre_ones", o, 60);
        chk("pre_zeros", z, 30);
        chk("pre_ready", in_ready, 1);

        // Single-flit packet.
        @(posedge clk); #1;
        seen.delete();
        offer(40'h00_0000_03FF, 2'd0);
        @(negedge clk);
        chk("p1_valid", link_valid_out, 1);
        chk("p1_out", link_out, 11'h7FF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p1_ready_after", in_ready, 1);
        chk("p1_valid_after", link_valid_out, 0);
        @(posedge clk); #1;
        chk("p1_count", seen.size(), 1);

        // Four flits back to back.
        seen.delete();
        offer(pkt, 2'd3);
        wait_idle();
        @(posedge clk); #1;
        chk("p4_count", seen.size(), 4);
        chk("p4_f0", seen[0], 11'h00F);
        chk("p4_f1", seen[1], 11'h001);
        chk("p4_f2", seen[2], 11'h003);
        chk("p4_f3", seen[3], 11'h407);

        // Stall five cycles on flit 1.
        seen.delete();
        offer(pkt, 2'd3);
        @(posedge clk); #1;
        link_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out", link_out, 11'h001);
            chk("stall_valid", link_valid_out, 1);
            @(posedge clk); #1;
        end
        link_ready_in = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        chk("stall_count", seen.size(), 4);
        chk("stall_f1", seen[1], 11'h001);
        chk("stall_f2", seen[2], 11'h003);
        chk("stall_f3", seen[3], 11'h407);

        // Reset request during flit 1: packet completes, then preamble.
        seen.delete();
        offer(pkt, 2'd3);
        @(posedge clk); #1;
        link_reset_req = 1'b1;
        @(posedge clk); #1;
        link_reset_req = 1'b0;
        measure(o, z);
        chk("req_ones", o, 60);
        chk("req_zeros", z, 30);
        @(posedge clk); #1;
        chk("req_count", seen.size(), 4);
        chk("req_tail", seen[3], 11'h407);

        // Hard reset mid-packet: valid drops at once, packet lost.
        seen.delete();
        offer(pkt, 2'd3);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", link_valid_out, 0);
        chk("mid_rst_out", link_out, 11'h7FF);
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        measure(o, z);
        chk("mid_ones", o, 60);
        chk("mid_zeros", z, 30);
        @(posedge clk); #1;
        chk("mid_lost", seen.size(), 1);

        // Reset request and packet in the same idle cycle: reset wins.
        seen.delete();
        link_reset_req = 1'b1;
        in_valid       = 1'b1;
        in_data        = pkt;
        in_nflits      = 2'd3;
        @(negedge clk);
        chk("both_ready", in_ready, 0);
        @(posedge clk); #1;
        link_reset_req = 1'b0;
        in_valid       = 1'b0;
        measure(o, z);
        chk("both_ones", o, 60);
        chk("both_zeros", z, 30);
        @(posedge clk); #1;
        chk("both_no_pkt", seen.size(), 0);

`ifdef LINK_TX_STATS_EN
        // Bring the counter to FFFE, then three more flits wrap it to 1.
        need = (32'hFFFE - m_fc) & 32'hFFFF;
        while (need >= 4) begin
            offer(pkt, 2'd3);
            need -= 4;
        end
        if (need > 0) offer(pkt, 2'(need - 1));
        wait_idle();
        chk("fc_preload", flit_count, 16'hFFFE);
        @(posedge clk); #1;
        offer(pkt, 2'd2);
        wait_idle();
        chk("fc_wrap", flit_count, 16'h0001);
`endif

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/link_flit_tx.md
LINK_FLIT_TX -- requirements
Module: link_flit_tx

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 60: cycles the link-reset word is driven.
REQ-002 SHALL have parameter IDLE_CYCLES, default 30: cycles the all-zero word is driven after the reset word.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  40  packet payload; chunk k is bits [10k+9:10k].
REQ-006 SHALL have port in_nflits  input  2  number of flits in the packet minus 1 (1..4 flits).
REQ-007 SHALL have port in_valid  input  1  packet offered.
REQ-008 SHALL have port in_ready  output  1  packet slot free.
REQ-009 SHALL have port link_reset_req  input  1  request a link-reset preamble.
REQ-010 SHALL have port link_out  output  11  flit; bit 10 is tail, bits [9:0] are payload.
REQ-011 SHALL have port link_valid_out  output  1  flit valid.
REQ-012 SHALL have port link_ready_in  input  1  downstream ready.

Function
REQ-013 SHALL implement FSM states RST_ONES, RST_ZEROS, IDLE, SEND.
REQ-014 RST_ONES SHALL drive link_out=11'h7FF with link_valid_out=0 for exactly RESET_CYCLES cycles, then go to RST_ZEROS.
REQ-015 RST_ZEROS SHALL drive link_out=11'h000 with link_valid_out=0 for exactly IDLE_CYCLES cycles, then go to IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE, and only when link_reset_req=0.
REQ-017 On in_valid&&in_ready, SHALL capture in_data and in_nflits, go to SEND, and assert link_valid_out on the next cycle (1-cycle latency).
REQ-018 SEND SHALL emit flit k={k==in_nflits, chunk k}, for k=0 up to in_nflits (low chunk first).
REQ-019 SHALL advance the flit only on link_valid_out&&link_ready_in; while waiting, link_out and link_valid_out SHALL hold stable.
REQ-020 After the tail handshake, SHALL go to IDLE, or to RST_ONES if link_reset_req was seen during SEND.
REQ-021 Once asserted, link_valid_out SHALL NOT deassert before the handshake except on reset.
REQ-022 In IDLE, link_out SHALL be 11'h000 and link_valid_out=0.
REQ-023 link_reset_req in IDLE SHALL enter RST_ONES on the next cycle.
REQ-024 link_reset_req and in_valid in the same IDLE cycle: reset wins and no packet is accepted.
REQ-025 A one-flit packet (in_nflits=0) SHALL emit a single flit with tail=1.

Reset
REQ-026 Assertion of reset SHALL immediately force state RST_ONES, link_valid_out=0, link_out=11'h7FF, in_ready=0, and clear the preamble counter.
REQ-027 reset asserted mid-packet SHALL discard the buffered packet; the preamble restarts from zero after release.

Configuration
REQ-028 When macro LINK_TX_STATS_EN is defined, SHALL add output flit_count (16 bits), reset to 0.
REQ-029 flit_count SHALL increment on each flit handshake and wrap 16'hFFFF to 0.
REQ-030 Without LINK_TX_STATS_EN, the flit_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package link_pkg SHALL hold FLIT_W=11, PAYLOAD_W=10, TAIL_BIT=10, LINK_RESET_WORD=11'h7FF, LINK_IDLE_WORD=11'h000, and the FSM state enum.
REQ-032 The preamble timer SHALL be sub-module link_reset_seq: start input, ones/zeros phase outputs, done output.

Verification
REQ-033 Release reset -> link_out=7FF for 60 cycles, then 000 for 30 cycles, then in_ready=1; link_valid_out=0 throughout.
REQ-034 Packet in_data=40'h00_0000_03FF, in_nflits=0, link_ready_in=1 -> one flit 11'h7FF with valid=1 one cycle after acceptance; then in_ready=1.
REQ-035 in_nflits=3, chunks 00F,001,003,007, link_ready_in=1 -> flits 00F,001,003,407 on consecutive cycles.
REQ-036 Same packet with link_ready_in=0 for 5 cycles at flit 1 -> link_out holds 001 with valid=1 for all 5 cycles; no flit skipped or duplicated.
REQ-037 link_reset_req pulsed during flit 1 of a 4-flit packet -> remaining flits complete, then 60 cycles of 7FF; reset asserted mid-packet -> valid=0 at once and the packet is lost.
REQ-038 With LINK_TX_STATS_EN defined, preload flit_count to 16'hFFFE via 2 fewer flits, send 3 flits -> flit_count reads 1.
